doc_monitor_pfc_sequencer: RTL and testbench

Avalon-MM controlled power-up sequencer for the PFC stage of the DOC monitor. It drives the 2-bit PFC control outputs (precharge relay, PFC enable) through a timed precharge → enable → power-good handshake, and watches the 2-bit PFC status inputs. On a fault it latches a cause and raises an interrupt. It replaces direct software bit-banging of the PFC PIO with a hardware-timed state machine, and sits on the same Avalon bus as the other monitor peripherals.

---
 rtl/doc_monitor_pfc_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_doc_monitor_pfc_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doc_monitor_pfc_sequencer.sv
// PFC power-up sequencer for the DOC monitor.
// An Avalon-MM slave runs a timed sequence: precharge relay, then PFC enable,
// then wait for power-good. A fault latches its cause and raises a level irq.
module doc_monitor_pfc_sequencer #(
    parameter int                 TIMER_W        = 24,
    parameter logic [TIMER_W-1:0] PRECHARGE_RST  = 24'd5_000_000,
    parameter logic [TIMER_W-1:0] PG_TIMEOUT_RST = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [1:0]  pfc_in,
    output logic [1:0]  pfc_out,
    output logic        irq
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_WAIT_PG   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_EXT     = 2'd1;
    localparam logic [1:0] CAUSE_PG_TO   = 2'd2;
    localparam logic [1:0] CAUSE_PG_LOST = 2'd3;

    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [1:0]         cause_reg, cause_next;
    logic               fault_latched_reg, fault_latched_next;
    logic [1:0]         pfc_out_reg, pfc_out_next;
    logic [1:0]         sync1_reg, sync2_reg;
    logic [TIMER_W-1:0] precharge_time_reg, pg_timeout_reg;
    logic [31:0]        readdata_reg, readdata_next;

    logic       pg_s, flt_s;
    logic       wr_en, ctrl_wr;
    logic       start, stop, clr_fault;
    logic [7:0] status_byte;

    assign pg_s  = sync2_reg[0];
    assign flt_s = sync2_reg[1];

    // Control bits act only for the cycle of the write; nothing is stored.
    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en & (address == 2'd0);
    assign start     = ctrl_wr & writedata[0];
    assign stop      = ctrl_wr & writedata[1];
    assign clr_fault = ctrl_wr & writedata[2];

    assign status_byte = {cause_reg, fault_latched_reg, flt_s, pg_s, state_reg};

    // Two-flop synchronizer for the asynchronous PFC status lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 2'b00;
            sync2_reg <= 2'b00;
        end else begin
            sync1_reg <= pfc_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Timer reload registers; a new value is picked up only at the next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            precharge_time_reg <= PRECHARGE_RST;
            pg_timeout_reg     <= PG_TIMEOUT_RST;
        end else if (wr_en) begin
            if (address == 2'd1) precharge_time_reg <= writedata[TIMER_W-1:0];
            if (address == 2'd3) pg_timeout_reg     <= writedata[TIMER_W-1:0];
        end
    end

    // Next-state logic: external fault beats PG timeout/loss, which beats stop, which beats start.
    always_comb begin
        state_next         = state_reg;
        timer_next         = timer_reg;
        cause_next         = cause_reg;
        fault_latched_next = fault_latched_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && !stop && !flt_s) begin
                    state_next = ST_PRECHARGE;
                    timer_next = precharge_time_reg;
                end
            end
            ST_PRECHARGE: begin
                if (flt_s) begin
                    state_next         = ST_FAULT;
                    cause_next         = CAUSE_EXT;
                    fault_latched_next = 1'b1;
                end else if (stop) begin
                    state_next = ST_IDLE;
                end else if (timer_reg == '0) begin
                    state_next = ST_WAIT_PG;
                    timer_next = pg_timeout_reg;
                end else begin
                    timer_next = timer_reg - TIMER_W'(1);
                end
            end
            ST_WAIT_PG: begin
                if (flt_s) begin
                    state_next         = ST_FAULT;
                    cause_next         = CAUSE_EXT;
                    fault_latched_next = 1'b1;
                end else if (!pg_s && timer_reg == '0) begin
                    state_next         = ST_FAULT;
                    cause_next         = CAUSE_PG_TO;
                    fault_latched_next = 1'b1;
                end else if (stop) begin
                    state_next = ST_IDLE;
                end else if (pg_s) begin
                    state_next = ST_RUN;
                end else begin
                    timer_next = timer_reg - TIMER_W'(1);
                end
            end
            ST_RUN: begin
                if (flt_s) begin
                    state_next         = ST_FAULT;
                    cause_next         = CAUSE_EXT;
                    fault_latched_next = 1'b1;
                end else if (!pg_s) begin
                    state_next         = ST_FAULT;
                    cause_next         = CAUSE_PG_LOST;
                    fault_latched_next = 1'b1;
                end else if (stop) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (clr_fault && !flt_s) begin
                    state_next         = ST_IDLE;
                    cause_next         = CAUSE_NONE;
                    fault_latched_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch together with it.
    always_comb begin
        pfc_out_next = 2'b00;
        case (state_next)
            ST_PRECHARGE: pfc_out_next = 2'b01;
            ST_WAIT_PG:   pfc_out_next = 2'b11;
            ST_RUN:       pfc_out_next = 2'b11;
            default:      pfc_out_next = 2'b00;
        endcase
    end

    // Read mux; its output is registered, giving one cycle of read latency.
    always_comb begin
        readdata_next = 32'd0;
        case (address)
            2'd1:    readdata_next = {{(32-TIMER_W){1'b0}}, precharge_time_reg};
            2'd2:    readdata_next = {24'd0, status_byte};
            2'd3:    readdata_next = {{(32-TIMER_W){1'b0}}, pg_timeout_reg};
            default: readdata_next = 32'd0;
        endcase
    end

    // State, timer, fault and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            timer_reg         <= '0;
            cause_reg         <= CAUSE_NONE;
            fault_latched_reg <= 1'b0;
            pfc_out_reg       <= 2'b00;
            readdata_reg      <= 32'd0;
        end else begin
            state_reg         <= state_next;
            timer_reg         <= timer_next;
            cause_reg         <= cause_next;
            fault_latched_reg <= fault_latched_next;
            pfc_out_reg       <= pfc_out_next;
            readdata_reg      <= readdata_next;
        end
    end

    assign pfc_out  = pfc_out_reg;
    assign irq      = fault_latched_reg;
    assign readdata = readdata_reg;

endmodule

// File: tb/tb_doc_monitor_pfc_sequencer.sv
// Self-checking bench for doc_monitor_pfc_sequencer: register and IDLE-state
// vector tables, followed by directed multi-cycle sequences.
module tb_doc_monitor_pfc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [1:0]  pfc_in = 2'b00;
    logic [1:0]  pfc_out;
    logic        irq;

    int checks = 0;
    int failures = 0;

    doc_monitor_pfc_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pfc_in     (pfc_in),
        .pfc_out    (pfc_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        bit          cs;
        logic [31:0] ctrl;
        logic [1:0]  pin;
        logic [1:0]  exp_out;
        logic [31:0] exp_status;
    } idle_vec_t;

    reg_vec_t  reg_tab[9];
    idle_vec_t idle_tab[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input bit cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    // Counts consecutive clock edges after which pfc_out equals v (bounded).
    task automatic count_run(input logic [1:0] v, input int init, output int cnt);
        cnt = init;
        while (pfc_out == v && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int cnt;

        reg_tab[0] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000};
        reg_tab[1] = '{1'b0, 2'd1, 32'h0000_0000, 32'd5_000_000};
        reg_tab[2] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000};
        reg_tab[3] = '{1'b0, 2'd3, 32'h0000_0000, 32'd10_000_000};
        reg_tab[4] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h00FF_FFFF};
        reg_tab[5] = '{1'b1, 2'd3, 32'hAB12_3456, 32'h0012_3456};
        reg_tab[6] = '{1'b1, 2'd1, 32'h0000_0032, 32'h0000_0032};
        reg_tab[7] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_0000};
        reg_tab[8] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0000};

        idle_tab[0] = '{1'b1, 32'd1, 2'b00, 2'b01, 32'h01};
        idle_tab[1] = '{1'b1, 32'd3, 2'b00, 2'b00, 32'h00};
        idle_tab[2] = '{1'b1, 32'd4, 2'b00, 2'b00, 32'h00};
        idle_tab[3] = '{1'b1, 32'd1, 2'b10, 2'b00, 32'h10};
        idle_tab[4] = '{1'b0, 32'd1, 2'b00, 2'b00, 32'h00};
        idle_tab[5] = '{1'b1, 32'd1, 2'b01, 2'b01, 32'h09};
        idle_tab[6] = '{1'b1, 32'd2, 2'b00, 2'b00, 32'h00};

        // Reset
        tick(3);
        reset_n = 1'b1;
        tick(1);
        check("reset_pfc_out", 32'(pfc_out), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_readdata", readdata, 32'd0);

        // Register readback table
        for (int i = 0; i < 9; i++) begin
            if (reg_tab[i].wr) bus_write(reg_tab[i].addr, reg_tab[i].wdata, 1'b1);
            bus_read(reg_tab[i].addr, rd);
            check($sformatf("reg_tab[%0d]", i), rd, reg_tab[i].exp);
        end

        // Single CONTROL writes from IDLE
        for (int i = 0; i < 7; i++) begin
            pfc_in = idle_tab[i].pin;
            tick(3);
            bus_write(2'd0, idle_tab[i].ctrl, idle_tab[i].cs);
            check($sformatf("idle_tab[%0d].pfc_out", i), 32'(pfc_out), 32'(idle_tab[i].exp_out));
            bus_read(2'd2, rd);
            check($sformatf("idle_tab[%0d].status", i), rd, idle_tab[i].exp_status);
            bus_write(2'd0, 32'd2, 1'b1);
            pfc_in = 2'b00;
            tick(3);
        end

        // Nominal sequence
        bus_write(2'd1, 32'd10, 1'b1);
        bus_write(2'd3, 32'd20, 1'b1);
        bus_write(2'd0, 32'd1, 1'b1);
        count_run(2'b01, 0, cnt);
        check("nominal_precharge_dwell", cnt, 32'd11);
        check("nominal_wait_pg_out", 32'(pfc_out), 32'b11);
        tick(4);
        pfc_in = 2'b01;
        tick(4);
        check("nominal_run_out", 32'(pfc_out), 32'b11);
        bus_read(2'd2, rd);
        check("nominal_status", rd, 32'h0B);
        check("nominal_irq", 32'(irq), 32'd0);

        // External fault in RUN, clr while held, clr after release
        pfc_in = 2'b11;
        tick(1);
        check("extflt_out_c1", 32'(pfc_out), 32'b11);
        tick(1);
        check("extflt_out_c2", 32'(pfc_out), 32'b11);
        tick(1);
        check("extflt_out_c3", 32'(pfc_out), 32'b00);
        check("extflt_irq", 32'(irq), 32'd1);
        bus_read(2'd2, rd);
        check("extflt_status", rd, 32'h7C);
        bus_write(2'd0, 32'd4, 1'b1);
        bus_read(2'd2, rd);
        check("extflt_clr_held_status", rd, 32'h7C);
        pfc_in = 2'b00;
        tick(3);
        bus_write(2'd0, 32'd4, 1'b1);
        bus_read(2'd2, rd);
        check("extflt_clr_status", rd, 32'h00);
        check("extflt_clr_irq", 32'(irq), 32'd0);

        // PG timeout
        bus_write(2'd0, 32'd1, 1'b1);
        count_run(2'b01, 0, cnt);
        check("pgto_precharge_dwell", cnt, 32'd11);
        count_run(2'b11, 0, cnt);
        check("pgto_wait_dwell", cnt, 32'd21);
        check("pgto_out", 32'(pfc_out), 32'b00);
        check("pgto_irq", 32'(irq), 32'd1);
        bus_read(2'd2, rd);
        check("pgto_status", rd, 32'hA4);
        bus_write(2'd0, 32'd4, 1'b1);
        bus_read(2'd2, rd);
        check("pgto_clr_status", rd, 32'h00);
        pfc_in = 2'b01;
        tick(3);
        bus_read(2'd2, rd);
        check("pgto_clr_status_pg", rd, 32'h08);
        pfc_in = 2'b00;
        tick(3);

        // Stop in WAIT_PG
        bus_write(2'd0, 32'd1, 1'b1);
        count_run(2'b01, 0, cnt);
        tick(2);
        bus_write(2'd0, 32'd2, 1'b1);
        check("stop_wait_out", 32'(pfc_out), 32'b00);
        bus_read(2'd2, rd);
        check("stop_wait_status", rd, 32'h00);
        check("stop_wait_irq", 32'(irq), 32'd0);

        // PG lost in RUN on the same edge as a stop write
        pfc_in = 2'b01;
        tick(3);
        bus_write(2'd0, 32'd1, 1'b1);
        count_run(2'b01, 0, cnt);
        tick(2);
        bus_read(2'd2, rd);
        check("pglost_run_status", rd, 32'h0B);
        pfc_in = 2'b00;
        tick(2);
        bus_write(2'd0, 32'd2, 1'b1);
        check("pglost_out", 32'(pfc_out), 32'b00);
        check("pglost_irq", 32'(irq), 32'd1);
        bus_read(2'd2, rd);
        check("pglost_status", rd, 32'hE4);
        bus_write(2'd0, 32'd4, 1'b1);
        bus_read(2'd2, rd);
        check("pglost_clr_status", rd, 32'h00);

        // PRECHARGE_TIME = 0
        bus_write(2'd1, 32'd0, 1'b1);
        bus_write(2'd0, 32'd1, 1'b1);
        count_run(2'b01, 0, cnt);
        check("pt0_dwell", cnt, 32'd1);
        bus_write(2'd0, 32'd2, 1'b1);

        // PRECHARGE_TIME rewritten mid-count
        bus_write(2'd1, 32'd10, 1'b1);
        bus_write(2'd0, 32'd1, 1'b1);
        check("midwr_start_out", 32'(pfc_out), 32'b01);
        bus_write(2'd1, 32'd50, 1'b1);
        count_run(2'b01, 1, cnt);
        check("midwr_current_dwell", cnt, 32'd11);
        bus_write(2'd0, 32'd2, 1'b1);
        bus_write(2'd0, 32'd1, 1'b1);
        count_run(2'b01, 0, cnt);
        check("midwr_next_dwell", cnt, 32'd51);
        bus_write(2'd0, 32'd2, 1'b1);
        bus_read(2'd1, rd);
        check("midwr_readback", rd, 32'h32);

        // Asynchronous reset in RUN
        pfc_in = 2'b01;
        tick(3);
        bus_write(2'd0, 32'd1, 1'b1);
        count_run(2'b01, 0, cnt);
        tick(2);
        check("rst_run_out", 32'(pfc_out), 32'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_out", 32'(pfc_out), 32'b00);
        check("rst_async_irq", 32'(irq), 32'd0);
        pfc_in = 2'b00;
        tick(2);
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        check("rst_pt_readback", rd, 32'd5_000_000);
        bus_read(2'd3, rd);
        check("rst_pg_readback", rd, 32'd10_000_000);
        bus_read(2'd2, rd);
        check("rst_status", rd, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
